// File: rtl/aes_key_expand_seq.sv
// AES key-schedule engine (128/192/256): one 32-bit word per cycle, round keys streamed as 128-bit beats.
// Latency: start at edge E0 -> rk[0] valid after E4; then one round key per 4 cycles without backpressure.
// Backpressure: generation freezes while a completed key waits on rk_ready=0; no beat is dropped.
// Optional: define AES_KEY_STORE_EN for an (NR+1)x128 round-key store with a registered read port.
module aes_key_expand_seq #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_idx,
    output logic                done
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]          rd_idx,
    output logic [127:0]        rd_data
`endif
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NK);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand_seq: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t      state;
    logic [31:0] win [NK];      // sliding window of the last NK schedule words, win[0] oldest
    logic [5:0]  wcnt;          // index i of the next word to produce
    logic [2:0]  modcnt;        // i mod NK, kept as a wrapping counter
    logic [7:0]  rcon;
    logic [3:0]  grp;           // index of the round key being assembled
    logic [31:0] asm0, asm1, asm2;

    logic [31:0] newest, rot_in, sub_out, tmp, gen_word;
    logic        out_free, step, hs;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254 by an addition chain) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, b;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        b    = gf_mul(x252, x2);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Next schedule word; the single S-box bank serves both the RotWord and the NK=8 mid-window case
    always_comb begin
        newest   = win[NK-1];
        rot_in   = (modcnt == 3'd0) ? {newest[23:0], newest[31:24]} : newest;
        sub_out  = {sbox(rot_in[31:24]), sbox(rot_in[23:16]), sbox(rot_in[15:8]), sbox(rot_in[7:0])};
        tmp      = newest;
        if (modcnt == 3'd0)
            tmp = sub_out ^ {rcon, 24'h000000};
        else if (NK == 8 && modcnt == 3'd4)
            tmp = sub_out;
        if (wcnt < 6'(NK))
            gen_word = win[wcnt[IW-1:0]];
        else
            gen_word = win[0] ^ tmp;
    end

    // The fourth word of a group goes straight to the output register, so it may only be produced when that is free
    assign hs       = rk_valid && rk_ready;
    assign out_free = !rk_valid || rk_ready;
    assign step     = (state == S_RUN) && ((wcnt[1:0] != 2'd3) || out_free);

    // Control FSM, word generation, assembly and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
            done     <= 1'b0;
            wcnt     <= '0;
            modcnt   <= '0;
            rcon     <= 8'h01;
            grp      <= '0;
            asm0     <= '0;
            asm1     <= '0;
            asm2     <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
        end else begin
            done <= 1'b0;
            if (hs) rk_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) win[k] <= key_in[KEY_BITS-1-32*k -: 32];
                        busy   <= 1'b1;
                        wcnt   <= '0;
                        modcnt <= '0;
                        rcon   <= 8'h01;
                        grp    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step) begin
                        wcnt   <= wcnt + 6'd1;
                        modcnt <= (modcnt == 3'(NK-1)) ? 3'd0 : modcnt + 3'd1;
                        if (wcnt >= 6'(NK)) begin
                            for (int k = 0; k < NK-1; k++) win[k] <= win[k+1];
                            win[NK-1] <= gen_word;
                            if (modcnt == 3'd0) rcon <= xtime(rcon);
                        end
                        case (wcnt[1:0])
                            2'd0: asm0 <= gen_word;
                            2'd1: asm1 <= gen_word;
                            2'd2: asm2 <= gen_word;
                            default: begin
                                rk_data  <= {asm0, asm1, asm2, gen_word};
                                rk_valid <= 1'b1;
                                rk_idx   <= grp;
                                grp      <= grp + 4'd1;
                                if (wcnt == 6'(NW-1)) state <= S_FLUSH;
                            end
                        endcase
                    end
                end
                S_FLUSH: begin
                    if (hs && rk_idx == 4'(NR)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef AES_KEY_STORE_EN
    logic [127:0] store [NR+1];

    // Keep every accepted round key for later (e.g. reverse-order) reads; wiped by a new start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NR; k++) store[k] <= '0;
            rd_data <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                for (int k = 0; k <= NR; k++) store[k] <= '0;
            end else if (hs) begin
                store[rk_idx] <= rk_data;
            end
            rd_data <= (rd_idx <= 4'(NR)) ? store[rd_idx] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: three instances (128/192/256) checked against a FIPS-197 reference model.
// Directed known-answer runs, backpressure, ignored start, async reset abort, randomized keys.
// Define AES_KEY_STORE_EN to also exercise the round-key store read port.
module tb_aes_key_expand_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   start_v, ready_v, busy_v, valid_v, done_v;
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;
    logic [127:0] d0, d1, d2;
    logic [3:0]   x0, x1, x2;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rdi0, rdi1, rdi2;
    logic [127:0] rdd0, rdd1, rdd2;
`endif

    aes_key_expand_seq #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key128), .busy(busy_v[0]),
        .rk_valid(valid_v[0]), .rk_ready(ready_v[0]), .rk_data(d0), .rk_idx(x0), .done(done_v[0])
`ifdef AES_KEY_STORE_EN
        , .rd_idx(rdi0), .rd_data(rdd0)
`endif
    );
    aes_key_expand_seq #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key192), .busy(busy_v[1]),
        .rk_valid(valid_v[1]), .rk_ready(ready_v[1]), .rk_data(d1), .rk_idx(x1), .done(done_v[1])
`ifdef AES_KEY_STORE_EN
        , .rd_idx(rdi1), .rd_data(rdd1)
`endif
    );
    aes_key_expand_seq #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key256), .busy(busy_v[2]),
        .rk_valid(valid_v[2]), .rk_ready(ready_v[2]), .rk_data(d2), .rk_idx(x2), .done(done_v[2])
`ifdef AES_KEY_STORE_EN
        , .rd_idx(rdi2), .rd_data(rdd2)
`endif
    );

    int           sel;
    logic [127:0] cur_data;
    logic [3:0]   cur_idx;
    always_comb begin
        cur_data = d0;
        cur_idx  = x0;
        case (sel)
            1: begin cur_data = d1; cur_idx = x1; end
            2: begin cur_data = d2; cur_idx = x2; end
            default: ;
        endcase
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sb [256];
    logic [127:0] ref_rk [15];
    logic [127:0] got [15];

    // S-box table built from the generator-3 walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    // Textbook key expansion; key is left-aligned in 256 bits
    task automatic expand(input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_key(input int s, input logic [255:0] k);
        case (s)
            0: key128 = k[255:128];
            1: key192 = k[255:64];
            default: key256 = k;
        endcase
    endtask

    // One full expansion on instance s; duty = rk_ready percentage; abort_at >= 0 drops rst_n after that edge
    task automatic run(input int s, input logic [255:0] key, input int duty, input bit mid_start,
                       input int abort_at, input string tag);
        int nk, nr, nb, beats, c;
        logic [127:0] held;
        bit stalled, aborted;
        nk = 4 + 2*s;
        nr = nk + 6;
        nb = nr + 1;
        expand(nk, key);
        sel = s;
        @(negedge clk);
        set_key(s, key);
        start_v[s] = 1'b1;
        ready_v[s] = 1'b0;
        @(posedge clk);
        #1;
        start_v[s] = 1'b0;
        set_key(s, ~key);
        c = 0; beats = 0; stalled = 0; aborted = 0;
        while (beats < nb && c < 3000 && !aborted) begin
            @(negedge clk);
            if (c == 0) chk({tag, " busy_after_start"}, 128'(busy_v[s]), 128'd1);
            if (c == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk({tag, " rst_busy"}, 128'(busy_v[s]), 128'd0);
                chk({tag, " rst_valid"}, 128'(valid_v[s]), 128'd0);
                chk({tag, " rst_data"}, cur_data, 128'd0);
                chk({tag, " rst_idx"}, 128'(cur_idx), 128'd0);
                chk({tag, " rst_done"}, 128'(done_v[s]), 128'd0);
                aborted = 1;
            end else begin
                ready_v[s] = ($urandom_range(99) < duty);
                if (mid_start) begin
                    start_v[s] = (c == 10);
                    if (c == 10) set_key(s, rand256());
                end
                if (stalled) begin
                    chk({tag, " stall_valid"}, 128'(valid_v[s]), 128'd1);
                    chk({tag, " stall_data"}, cur_data, held);
                end
                stalled = 0;
                if (valid_v[s]) begin
                    if (ready_v[s]) begin
                        chk({tag, " rk_idx"}, 128'(cur_idx), 128'(beats));
                        chk({tag, " rk_data"}, cur_data, ref_rk[beats]);
                        got[beats] = cur_data;
                        if (duty >= 100 && (beats == 0 || beats == nr))
                            chk({tag, " latency"}, 128'(c), 128'(4*(beats+1)));
                        beats++;
                    end else begin
                        held    = cur_data;
                        stalled = 1;
                    end
                end
                @(posedge clk);
                c++;
            end
        end
        if (aborted) return;
        if (beats < nb) chk({tag, " beat_count_timeout"}, 128'(beats), 128'(nb));
        @(negedge clk);
        ready_v[s] = 1'b0;
        chk({tag, " done_pulse"}, 128'(done_v[s]), 128'd1);
        chk({tag, " busy_end"}, 128'(busy_v[s]), 128'd0);
        chk({tag, " valid_end"}, 128'(valid_v[s]), 128'd0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 128'(done_v[s]), 128'd0);
    endtask

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] RK12   = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK14   = 128'hfe4890d1e6188d0b046df344706c631e;

    initial begin
        logic [255:0] k1;
        k1      = {K128, 128'h0};
        sel     = 0;
        rst_n   = 1'b0;
        start_v = '0;
        ready_v = '0;
        key128  = '0;
        key192  = '0;
        key256  = '0;
`ifdef AES_KEY_STORE_EN
        rdi0 = '0; rdi1 = '0; rdi2 = '0;
`endif
        build_sbox();
        #1;
        chk("reset busy", 128'(busy_v), 128'd0);
        chk("reset valid", 128'(valid_v), 128'd0);
        chk("reset done", 128'(done_v), 128'd0);
        chk("reset data128", d0, 128'd0);
        chk("reset idx256", 128'(x2), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known-answer runs
        run(0, k1, 100, 0, -1, "t1_128");
        chk("t1 rk0", got[0], K128);
        chk("t1 rk1", got[1], RK1);
        chk("t1 rk10", got[10], RK10);
`ifdef AES_KEY_STORE_EN
        @(negedge clk); rdi0 = 4'd10;
        @(negedge clk); chk("store rd10", rdd0, RK10); rdi0 = 4'd15;
        @(negedge clk); chk("store rd15", rdd0, 128'd0); rdi0 = 4'd0;
        @(negedge clk); chk("store rd0", rdd0, K128);
`endif
        run(1, {K192, 64'h0}, 100, 0, -1, "t2_192");
        chk("t2 rk12", got[12], RK12);
        run(2, K256, 100, 0, -1, "t3_256");
        chk("t3 rk14", got[14], RK14);

        // Backpressure
        run(0, k1, 30, 0, -1, "t4_bp");
        chk("t4 rk10", got[10], RK10);

        // Ignored start, reset abort, then restart
        run(0, k1, 100, 1, -1, "t5_midstart");
        chk("t5 rk10", got[10], RK10);
        run(0, k1, 100, 0, 20, "t5_abort");
        repeat (2) @(negedge clk);
        chk("t5 no_done_in_reset", 128'(done_v[0]), 128'd0);
        rst_n = 1'b1;
        run(0, k1, 100, 0, -1, "t5_restart");
        chk("t5 restart rk10", got[10], RK10);

        // Randomized keys against the model
        for (int rep = 0; rep < 2; rep++) begin
            for (int s = 0; s < 3; s++) begin
                run(s, rand256(), (rep == 0) ? 100 : 60, 0, -1, "rand");
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
